// File: rtl/mem_responder.sv
// Memory-side responder for the multicycle core: word-addressed RAM with a
// configurable number of wait states, a one-cycle ready pulse and error reporting.
module mem_responder #(
    parameter int WIDTH     = 8,
    parameter int ADDR_BITS = 6,
    parameter int WAIT      = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             memread,
    input  logic             memwrite,
    input  logic [WIDTH-1:0] adr,
    input  logic [WIDTH-1:0] writedata,
    output logic [WIDTH-1:0] memdata,
    output logic             ready,
    output logic             busy,
    output logic             err
);

    localparam int DEPTH = 2 ** ADDR_BITS;
    localparam logic [3:0] WAIT_INIT = (WAIT == 0) ? 4'd0 : 4'(WAIT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [WIDTH-1:0]       adr_q, adr_d;
    logic [WIDTH-1:0]       wdata_q, wdata_d;
    logic                   wr_q, wr_d;
    logic [WIDTH-1:0]       memdata_q, memdata_d;
    logic                   ready_q, ready_d;
    logic                   busy_q, busy_d;
    logic                   err_q, err_d;
    logic                   commit_s;
    logic                   oor_s;
    logic                   mem_we_s;
    logic [ADDR_BITS-1:0]   idx_s;
    logic [WIDTH-1:0]       mem [DEPTH];

    // Next-state logic; commit decisions use the _d copies so WAIT==0 sees the live request.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        adr_d     = adr_q;
        wdata_d   = wdata_q;
        wr_d      = wr_q;
        case (state_q)
            S_IDLE: begin
                if (memread ^ memwrite) begin
                    adr_d   = adr;
                    wdata_d = writedata;
                    wr_d    = memwrite;
                    if (WAIT == 0) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = WAIT_INIT;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        commit_s = (state_d == S_RESP) && (state_q != S_RESP);
        oor_s    = (adr_d >> ADDR_BITS) != {WIDTH{1'b0}};
        idx_s    = adr_d[ADDR_BITS-1:0];
        mem_we_s = commit_s && wr_d && !oor_s;

        if (commit_s && !wr_d) begin
            memdata_d = oor_s ? {WIDTH{1'b0}} : mem[idx_s];
        end else begin
            memdata_d = memdata_q;
        end

        ready_d = (state_d == S_RESP);
        busy_d  = (state_d != S_IDLE);
        err_d   = ((state_q == S_IDLE) && memread && memwrite) || (commit_s && oor_s);
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            adr_q     <= {WIDTH{1'b0}};
            wdata_q   <= {WIDTH{1'b0}};
            wr_q      <= 1'b0;
            memdata_q <= {WIDTH{1'b0}};
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            adr_q     <= adr_d;
            wdata_q   <= wdata_d;
            wr_q      <= wr_d;
            memdata_q <= memdata_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
        end
    end

    // RAM array is never cleared; reset only blocks an uncommitted write.
    always_ff @(posedge clk) begin
        if (!reset && mem_we_s) begin
            mem[idx_s] <= wdata_d;
        end
    end

    assign memdata = memdata_q;
    assign ready   = ready_q;
    assign busy    = busy_q;
    assign err     = err_q;

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the multicycle core's memory interface. The core issues memread/memwrite with adr/writedata and holds them; this block answers with memdata and a one-cycle ready.
- Models a word-addressed RAM of 2**ADDR_BITS entries with a configurable number of wait states. It replaces the zero-latency behavioural memory in system-level simulation and FPGA builds.

Parameters:
- WIDTH, 8, data and address width in bits (matches the datapath width).
- ADDR_BITS, 6, implemented address bits; DEPTH = 2**ADDR_BITS words; legal range 1..WIDTH.
- WAIT, 2, wait states inserted before ready; legal range 0..15.

Ports:
- clk  input  1  rising-edge clock, the only clock.
- reset  input  1  synchronous, active-high reset.
- memread  input  1  read request, level; held by the core until ready.
- memwrite  input  1  write request, level; held by the core until ready.
- adr  input  WIDTH  word address.
- writedata  input  WIDTH  write data.
- memdata  output  WIDTH  read data; valid when ready=1; held until the next read completes.
- ready  output  1  one-cycle completion pulse.
- busy  output  1  high while a request is in flight (WAIT or RESP).
- err  output  1  one-cycle error pulse.

Behaviour:
- One clock (clk). Reset is synchronous and active-high (reset); it is sampled only on the rising edge of clk.
- Reset values: memdata=0, ready=0, busy=0, err=0, state=IDLE, wait counter=0. The RAM array is not cleared.
- States:
  - IDLE: busy=0. At an edge with exactly one of memread/memwrite=1, latch adr, writedata and op. Go to RESP if WAIT==0; otherwise go to WAIT with counter=WAIT-1.
  - WAIT: busy=1. Decrement the counter each edge; at the edge where counter==0, go to RESP.
  - RESP: busy=1, ready=1 for exactly this cycle; next edge returns to IDLE.
- Latency: a request sampled at edge N drives ready high in the cycle following edge N+WAIT. The request is visible for WAIT+1 cycles before ready.
- Commit: the write to RAM and the read capture into memdata both occur on the edge that enters RESP.
  - Reads: memdata = RAM[adr_latched[ADDR_BITS-1:0]].
  - Writes: memdata is unchanged.
- Requests in WAIT and RESP are ignored: no relatching, and a change of adr/writedata mid-flight has no effect.
- The core must deassert its request in the ready cycle. A request still high in IDLE on the following edge is accepted as a new request; this is legal back-to-back operation.
- memread and memwrite both high in IDLE: not accepted. err=1 for one cycle, state stays IDLE, no RAM or memdata change.
- Out of range: applies when ADDR_BITS<WIDTH and adr[WIDTH-1:ADDR_BITS]!=0.
  - The request is accepted and runs the full latency.
  - At RESP, err=1 together with ready=1.
  - Reads return memdata=0; writes are dropped.
- Index wrap: only adr[ADDR_BITS-1:0] indexes the RAM; there is no modulo arithmetic beyond truncation.
- Reset mid-operation: reset at any edge forces IDLE and the reset output values. A write not yet committed (reset at or before the RESP-entry edge) is discarded. Already-committed RAM contents persist.
- Reset has priority over all request handling on the same edge.

Test Plan:
- WAIT=2: write adr=0x05, writedata=0xA5 held until ready → ready exactly 3 cycles after the accept edge, busy=1 for 3 cycles. Then read adr=0x05 → memdata=0xA5 with ready, err=0.
- WAIT=0: read of adr=0x3F after writing 0x3C to it → ready the cycle after accept, memdata=0x3C. Back-to-back reads of 0x00 then 0x3F → ready every 2nd cycle.
- memread=memwrite=1 in IDLE → err=1 for one cycle, ready=0, busy=0. A subsequent read of the target address returns its prior value.
- ADDR_BITS=6: write 0x77 to adr=0x45 → ready=1 and err=1 same cycle. Read adr=0x05 → prior value, not 0x77. Read adr=0x45 → memdata=0x00, err=1.
- WAIT=3: write 0x11 to adr=0x10, reset asserted one edge after accept → outputs at reset values next cycle. Read adr=0x10 → old value, not 0x11.
- WAIT=2: adr changed from 0x01 to 0x02 during WAIT → the response reflects adr=0x01. A request toggled high during RESP is not accepted until IDLE.
